// File: rtl/fft32_com_ctrl.sv
// Commutator sequencer for the 32-point radix-2 MDC FFT: tracks valid pairs
// through four stages and decodes each commutator's mode and swap flag.

module fft32_com_cnt #(
  parameter int SEL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_o
);
  logic [3:0] cnt_q, cnt_d;

  // Holds across valid gaps so a stalled frame keeps its phase.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign bit_o = cnt_q[SEL];
endmodule

module fft32_com_ctrl #(
  parameter int STAGE_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       clear,
  input  logic [4:0] cfg_bypass,
  output logic [4:0] state_com_mode,
  output logic [4:0] com_flag,
  output logic       out_valid,
  output logic       frame_done,
  output logic       busy
);
  localparam int DEPTH = 4 * STAGE_LAT;

  logic [DEPTH:0] vld_pipe_q, vld_pipe_d;
  logic [4:1]     stg_vld;
  logic [4:1]     stg_bit;
  logic [3:0]     out_cnt_q, out_cnt_d;

  // Tap (k-1)*STAGE_LAT is vk; the last tap is out_valid.
  always_comb begin
    vld_pipe_d = clear ? '0 : {vld_pipe_q[DEPTH-1:0], in_valid};
    out_cnt_d  = out_cnt_q;
    if (clear)          out_cnt_d = '0;
    else if (out_valid) out_cnt_d = out_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe_q <= '0;
      out_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      out_cnt_q  <= out_cnt_d;
    end

  generate
    for (genvar k = 1; k <= 4; k++) begin : g_stg
      assign stg_vld[k] = vld_pipe_q[(k-1)*STAGE_LAT];
      fft32_com_cnt #(.SEL(4-k)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .en_i    (stg_vld[k]),
        .bit_o   (stg_bit[k])
      );
      assign state_com_mode[k] = ~stg_vld[k] | cfg_bypass[k];
      assign com_flag[k]       = ~stg_bit[k];
    end
  endgenerate

  assign state_com_mode[0] = 1'b1;
  assign com_flag[0]       = 1'b1;
  assign out_valid         = vld_pipe_q[DEPTH];
  assign frame_done        = out_valid & (&out_cnt_q);
  assign busy              = |vld_pipe_q;

  // cfg_bypass[0] is meaningless: stage 0 is always bypassed.
  logic unused_byp0;
  assign unused_byp0 = cfg_bypass[0];
endmodule
